// File: rtl/parallax_bg_renderer.sv
// Multi-layer scrolling background renderer: maps the linear pixel address to per-layer
// pixel-map addresses, steps each layer's scroll offset on frame ticks, and composites the layers.
module parallax_bg_renderer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BG_WIDTH      = 260,
    parameter int BG_HEIGHT     = 480,
    parameter int NUM_LAYERS    = 2,
    parameter int DIV_WIDTH     = 16,
    parameter int PIDX_WIDTH    = 17,
    parameter int CIDX_WIDTH    = 16,
    parameter logic [CIDX_WIDTH-1:0] TRANSPARENT_CIDX = '0
) (
    input  logic                             iClock,
    input  logic                             iResetN,
    input  logic [18:0]                      iAddress,
    input  logic                             iValid,
    input  logic                             iScrollEnable,
    input  logic [NUM_LAYERS-1:0]            iScrollDir,
    input  logic [NUM_LAYERS*DIV_WIDTH-1:0]  iDivider,
    output logic [NUM_LAYERS*PIDX_WIDTH-1:0] oPidx,
    input  logic [NUM_LAYERS*CIDX_WIDTH-1:0] iCidx,
    output logic [CIDX_WIDTH-1:0]            oCidx,
    output logic                             oValid,
    output logic                             oFrameStart
);
    localparam int X_W        = $clog2(SCREEN_WIDTH);
    localparam int Y_W        = $clog2(SCREEN_HEIGHT);
    localparam int OFF_W      = $clog2(BG_WIDTH);
    localparam int NUM_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;

    logic                            armed;
    logic                            tick;
    logic                            frame_start;
    logic                            scroll_en_q;
    logic [NUM_LAYERS-1:0]           dir_q;
    logic [NUM_LAYERS*DIV_WIDTH-1:0] div_q;
    logic [X_W-1:0]                  x_q;
    logic [Y_W-1:0]                  y_q;
    logic                            v0, v1, v2;
    logic [CIDX_WIDTH-1:0]           cidx_sel;

    // Armed drops on address 0 and re-arms on any other valid address, so a held
    // address 0 yields a single tick.
    assign tick = iValid && (iAddress == '0) && armed;

    // Scroll controls are captured with the tick; offsets then move one cycle later,
    // so pixel 0 of the new frame still sees the old offsets.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            armed       <= 1'b1;
            frame_start <= 1'b0;
            scroll_en_q <= 1'b0;
            dir_q       <= '0;
            div_q       <= '0;
        end else begin
            frame_start <= tick;
            if (iValid) armed <= (iAddress != '0);
            if (tick) begin
                scroll_en_q <= iScrollEnable;
                dir_q       <= iScrollDir;
                div_q       <= iDivider;
            end
        end
    end

    assign oFrameStart = frame_start;

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            x_q <= '0;
            y_q <= '0;
            v0  <= 1'b0;
        end else begin
            x_q <= X_W'(iAddress % 19'(SCREEN_WIDTH));
            y_q <= Y_W'(iAddress / 19'(SCREEN_WIDTH));
            v0  <= iValid && (iAddress < 19'(NUM_PIXELS));
        end
    end

    for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
        logic [DIV_WIDTH-1:0]  timer;
        logic [OFF_W-1:0]      offset;
        logic [PIDX_WIDTH-1:0] pidx_q;
        logic [DIV_WIDTH-1:0]  div_l;
        logic [31:0]           col, row, pidx_next;

        assign div_l = div_q[l*DIV_WIDTH +: DIV_WIDTH];

        always_ff @(posedge iClock or negedge iResetN) begin
            if (!iResetN) begin
                timer  <= '0;
                offset <= '0;
            end else if (frame_start && scroll_en_q && (div_l != '0)) begin
                if (timer >= div_l - DIV_WIDTH'(1)) begin
                    timer <= '0;
                    if (!dir_q[l])
                        offset <= (offset == OFF_W'(BG_WIDTH - 1)) ? '0 : offset + OFF_W'(1);
                    else
                        offset <= (offset == '0) ? OFF_W'(BG_WIDTH - 1) : offset - OFF_W'(1);
                end else begin
                    timer <= timer + DIV_WIDTH'(1);
                end
            end
        end

        // 32-bit intermediates keep x+offset and the row product exact before the modulo.
        assign col       = (32'(x_q) + 32'(offset)) % BG_WIDTH;
        assign row       = 32'(y_q) % BG_HEIGHT;
        assign pidx_next = col + row * BG_WIDTH;

        always_ff @(posedge iClock or negedge iResetN) begin
            if (!iResetN)  pidx_q <= '0;
            else if (v0)   pidx_q <= PIDX_WIDTH'(pidx_next);
        end

        assign oPidx[l*PIDX_WIDTH +: PIDX_WIDTH] = pidx_q;
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= v0;
            v2 <= v1;
        end
    end

    // Later layers override earlier ones; layer 0 is the fallback when all are transparent.
    // NOTE: cidx_sel gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        cidx_sel = iCidx[0 +: CIDX_WIDTH];
        for (int l = 1; l < NUM_LAYERS; l++) begin
            if (iCidx[l*CIDX_WIDTH +: CIDX_WIDTH] != TRANSPARENT_CIDX)
                cidx_sel = iCidx[l*CIDX_WIDTH +: CIDX_WIDTH];
        end
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            oCidx  <= '0;
            oValid <= 1'b0;
        end else begin
            oValid <= v2;
            if (v2) oCidx <= cidx_sel;
        end
    end

endmodule

// File: tb/tb_parallax_bg_renderer.sv
// Self-checking bench for parallax_bg_renderer: vector table, directed scroll/tick
// sequences and a randomized stream against a frame-level reference model.
module tb_parallax_bg_renderer;
    localparam int NL = 2;
    localparam int PW = 17;
    localparam int CW = 16;
    localparam int DW = 16;

    logic              iClock = 1'b0;
    logic              iResetN;
    logic [18:0]       iAddress;
    logic              iValid;
    logic              iScrollEnable;
    logic [NL-1:0]     iScrollDir;
    logic [NL*DW-1:0]  iDivider;
    logic [NL*PW-1:0]  oPidx;
    logic [NL*CW-1:0]  iCidx;
    logic [CW-1:0]     oCidx;
    logic              oValid;
    logic              oFrameStart;

    parallax_bg_renderer dut (
        .iClock(iClock), .iResetN(iResetN), .iAddress(iAddress), .iValid(iValid),
        .iScrollEnable(iScrollEnable), .iScrollDir(iScrollDir), .iDivider(iDivider),
        .oPidx(oPidx), .iCidx(iCidx), .oCidx(oCidx), .oValid(oValid),
        .oFrameStart(oFrameStart)
    );

    always #5 iClock = ~iClock;

    // Synchronous pixel-map ROM model; an override forces fixed per-layer data.
    logic [CW-1:0] rom_q [NL];
    logic          ovr_en;
    logic [CW-1:0] ovr [NL];

    function automatic logic [CW-1:0] rom_fn(int p, int l);
        if ((p + l) % 3 == 0) return '0;
        return CW'((p * 31 + l * 977) % 65521 + 1);
    endfunction

    always @(posedge iClock)
        for (int l = 0; l < NL; l++)
            rom_q[l] <= ovr_en ? ovr[l] : rom_fn(int'(oPidx[l*PW +: PW]), l);

    assign iCidx = {rom_q[1], rom_q[0]};

    typedef struct {
        bit valid;
        bit tick;
        int pidx0;
        int pidx1;
        int cidx;
    } rec_t;

    typedef struct {
        logic [18:0] addr;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        int  exp_pidx0;
        bit  exp_valid;
        int  exp_cidx;
    } vec_t;

    int   off [NL];
    int   tmr [NL];
    bit   armed;
    int   cidx_hold;
    rec_t hist [4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            off[l] = 0;
            tmr[l] = 0;
        end
        armed     = 1'b1;
        cidx_hold = 0;
        for (int i = 0; i < 4; i++) hist[i] = '{0, 0, 0, 0, 0};
    endtask

    // Frame-level reference: address the pixel with the current offsets, then let a tick move them.
    task automatic model_step(input logic [18:0] a, input logic v, output rec_t r);
        int x, y, ab, div;
        int p [NL];
        int c;
        bit found;
        ab = int'(a);
        x  = ab % 640;
        y  = ab / 640;
        r.valid = v && (ab < 640 * 480);
        for (int l = 0; l < NL; l++) p[l] = ((x + off[l]) % 260) + (y % 480) * 260;
        r.pidx0 = p[0];
        r.pidx1 = p[1];
        found = 1'b0;
        c = 0;
        for (int l = NL - 1; l >= 0; l--) begin
            int val;
            val = int'(ovr_en ? ovr[l] : rom_fn(p[l], l));
            if (!found && (val != 0)) begin
                c = val;
                found = 1'b1;
            end
        end
        if (!found) c = int'(ovr_en ? ovr[0] : rom_fn(p[0], 0));
        r.cidx = c;
        r.tick = v && (ab == 0) && armed;
        if (v) armed = (ab != 0);
        if (r.tick && iScrollEnable) begin
            for (int l = 0; l < NL; l++) begin
                div = int'(iDivider[l*DW +: DW]);
                if (div != 0) begin
                    if (tmr[l] >= div - 1) begin
                        tmr[l] = 0;
                        off[l] = iScrollDir[l] ? (off[l] + 259) % 260 : (off[l] + 1) % 260;
                    end else begin
                        tmr[l] = tmr[l] + 1;
                    end
                end
            end
        end
    endtask

    task automatic score();
        check("frame_start", oFrameStart, hist[0].tick);
        if (hist[1].valid) begin
            check("pidx0", oPidx[PW-1:0], hist[1].pidx0);
            check("pidx1", oPidx[2*PW-1:PW], hist[1].pidx1);
        end
        check("out_valid", oValid, hist[3].valid);
        if (hist[3].valid) cidx_hold = hist[3].cidx;
        check("cidx", oCidx, cidx_hold);
    endtask

    task automatic cycle(input logic [18:0] a, input logic v);
        rec_t r;
        iAddress = a;
        iValid   = v;
        model_step(a, v, r);
        @(posedge iClock);
        @(negedge iClock);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = r;
        score();
    endtask

    task automatic reset_pulse(input logic v);
        iValid   = v;
        iAddress = 19'd1234;
        iResetN  = 1'b0;
        #1;
        check("rst_pidx", oPidx, 0);
        check("rst_cidx", oCidx, 0);
        check("rst_valid", oValid, 0);
        check("rst_fstart", oFrameStart, 0);
        @(posedge iClock);
        @(negedge iClock);
        check("rst_edge_pidx", oPidx, 0);
        check("rst_edge_valid", oValid, 0);
        iResetN = 1'b1;
        model_reset();
    endtask

    initial begin
        vec_t vecs [5];
        int   exp_seq [4];
        int   fs_count;
        logic [18:0] ra;
        int   sel;

        vecs[0] = '{19'd5,      16'd7, 16'd0, 5,      1'b1, 7};
        vecs[1] = '{19'd639,    16'd7, 16'd9, 119,    1'b1, 9};
        vecs[2] = '{19'd307200, 16'd5, 16'd5, 0,      1'b0, 9};
        vecs[3] = '{19'd306561, 16'd0, 16'd0, 124541, 1'b1, 0};
        vecs[4] = '{19'd1000,   16'd0, 16'd4, 360,    1'b1, 4};
        exp_seq = '{0, 0, 1, 1};

        iResetN       = 1'b1;
        iAddress      = '0;
        iValid        = 1'b0;
        iScrollEnable = 1'b0;
        iScrollDir    = '0;
        iDivider      = '0;
        ovr_en        = 1'b0;
        ovr[0]        = '0;
        ovr[1]        = '0;
        #2;
        reset_pulse(1'b0);

        // Reset in the middle of a valid stream discards everything in flight.
        for (int a = 10; a < 15; a++) cycle(19'(a), 1'b1);
        reset_pulse(1'b1);

        // Vector table: addressing boundaries and compositing, offsets at 0.
        for (int i = 0; i < 5; i++) begin
            ovr_en = 1'b1;
            ovr[0] = vecs[i].c0;
            ovr[1] = vecs[i].c1;
            cycle(vecs[i].addr, 1'b1);
            cycle(19'd0, 1'b0);
            if (vecs[i].exp_valid) check("vec_pidx0", oPidx[PW-1:0], vecs[i].exp_pidx0);
            cycle(19'd0, 1'b0);
            cycle(19'd0, 1'b0);
            check("vec_valid", oValid, vecs[i].exp_valid);
            check("vec_cidx", oCidx, vecs[i].exp_cidx);
        end
        ovr_en = 1'b0;

        // Divider 2: pixel 0 of successive frames sees offsets 0,0,1,1.
        iScrollEnable = 1'b1;
        iScrollDir    = 2'b00;
        iDivider      = {16'd0, 16'd2};
        for (int f = 0; f < 4; f++) begin
            cycle(19'd0, 1'b1);
            cycle(19'd1, 1'b1);
            check("div2_frame_pidx", oPidx[PW-1:0], exp_seq[f]);
        end

        // Offset wrap in both directions.
        reset_pulse(1'b0);
        iScrollEnable = 1'b1;
        iDivider      = {16'd0, 16'd1};
        iScrollDir    = 2'b01;
        cycle(19'd0, 1'b1);
        cycle(19'd639, 1'b1);
        cycle(19'd1, 1'b1);
        check("wrap_rev_639", oPidx[PW-1:0], 118);
        iScrollDir = 2'b00;
        cycle(19'd0, 1'b1);
        cycle(19'd1, 1'b1);
        check("tick_pixel0_old_offset", oPidx[PW-1:0], 259);
        cycle(19'd639, 1'b1);
        cycle(19'd1, 1'b1);
        check("wrap_fwd_639", oPidx[PW-1:0], 119);

        // Held address 0 gives one tick; disabled scrolling freezes offsets.
        cycle(19'd5, 1'b1);
        fs_count = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(19'd0, 1'b1);
            fs_count += int'(oFrameStart);
        end
        check("one_tick_held_zero", fs_count, 1);
        iScrollEnable = 1'b0;
        for (int f = 0; f < 5; f++) begin
            cycle(19'd0, 1'b1);
            cycle(19'd9, 1'b1);
            check("disabled_hold_pidx", oPidx[PW-1:0], 1);
        end

        // Back-to-back stream across the last line and past the visible area.
        for (int a = 640 * 479 - 3; a <= 640 * 480 + 1; a++) cycle(19'(a), 1'b1);

        // Randomized stream with random scroll controls.
        for (int i = 0; i < 3000; i++) begin
            iScrollEnable = ($urandom_range(0, 3) != 0);
            iScrollDir    = NL'($urandom_range(0, 3));
            iDivider      = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
            sel = int'($urandom_range(0, 15));
            if (sel < 2)       ra = 19'd0;
            else if (sel == 2) ra = 19'($urandom_range(307200, 524287));
            else if (sel == 3) ra = 19'd307199;
            else               ra = 19'($urandom_range(1, 307199));
            cycle(ra, ($urandom_range(0, 7) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(19'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
